// File: rtl/fetch_queue_pkg.sv
// Shared constants for the fetch queue: default PC and instruction widths
// plus a helper that sizes the occupancy counter.
package fetch_queue_pkg;

  // Default PC width used by the fetch/decode path.
  localparam int unsigned ADDR_SIZE_DEF  = 32;

  // Default instruction word width.
  localparam int unsigned INSTR_SIZE_DEF = 32;

  // Default number of queue entries (power of two, at least 2).
  localparam int unsigned DEPTH_DEF      = 4;

  // The counter must represent 0..depth inclusive, so it needs one bit more
  // than the pointers.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue.sv
// Fetch queue: a small first-word-fall-through FIFO that decouples the fetch
// stage from decode. Each entry pairs a PC with its instruction word.
//
// Validity is defined only by the pointers and the occupancy count; the
// storage array itself is never cleared. A flush (redirect) empties the
// queue in one cycle, and reset overrides flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int unsigned INSTR_SIZE = INSTR_SIZE_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [ADDR_SIZE-1:0]             in_pc,
  input  logic [INSTR_SIZE-1:0]            in_instr,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [ADDR_SIZE-1:0]             out_pc,
  output logic [INSTR_SIZE-1:0]            out_instr,
  input  logic                             out_ready,
  output logic [count_width(DEPTH)-1:0]    count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = count_width(DEPTH);

  // Storage: PC and instruction kept in parallel arrays, indexed together so
  // they always leave as a pair.
  logic [ADDR_SIZE-1:0]  pc_mem    [DEPTH];
  logic [INSTR_SIZE-1:0] instr_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push;
  logic pop;

  // Handshake status comes from registered state only, so neither in_ready
  // nor out_valid depends combinationally on the same-cycle inputs. A full
  // queue refuses a push even if a pop happens in that cycle.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);

  // A redirect suppresses both transfers; the flushed-in entry is dropped.
  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // First-word fall-through: the head is read straight from storage.
  assign out_pc    = pc_mem[rd_ptr_q];
  assign out_instr = instr_mem[rd_ptr_q];
  assign count     = count_q;

  // Next-state for pointers and occupancy; flush clears everything.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are log2(DEPTH) bits, so incrementing past DEPTH-1 wraps
      // to 0 naturally.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;  // idle, or push+pop balances out
      endcase
    end
  end

  // Pointer and count registers; synchronous reset overrides flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write on an accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; contents outside the valid
    // window are never observed, and leaving it unreset lets it map to RAM.
    if (push) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, 32-bit PC/instr).
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic [2:0]  count;

  int n_cmp;
  int n_err;

  fetch_queue #(
    .ADDR_SIZE (32),
    .INSTR_SIZE(32),
    .DEPTH     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_pc   (out_pc),
    .out_instr(out_instr),
    .out_ready(out_ready),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word tied to its PC so pc/instr pairing can be checked.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_5A00;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = instr_of(pc);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".pc"},    64'(out_pc),    64'(pc));
    check({tag, ".instr"}, 64'(out_instr), 64'(instr_of(pc)));
  endtask

  logic [31:0] fill_pcs [4];
  logic [31:0] drain_pcs [4];

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    out_ready = 1'b0;

    // ---- Reset state
    step();
    step();
    check("rst.count",     64'(count),     64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    reset = 1'b0;
    step();
    check("post_rst.count", 64'(count), 64'd0);

    // ---- Fill: head stays 0x00 while decode stalls
    fill_pcs = '{32'h00, 32'h04, 32'h08, 32'h0C};
    for (int i = 0; i < 4; i++) begin
      set_push(fill_pcs[i]);
      step();
      check($sformatf("fill%0d.count", i), 64'(count), 64'(i + 1));
      check_head($sformatf("fill%0d.head", i), 32'h00);
    end
    check("full.in_ready", 64'(in_ready), 64'd0);
    // Push on full without a pop: nothing changes.
    set_push(32'hEE);
    step();
    check("full_push.count", 64'(count), 64'd4);
    check_head("full_push.head", 32'h00);
    in_valid = 1'b0;

    // ---- Drain two, refill across the pointer wrap, then drain all
    out_ready = 1'b1;
    step();
    check_head("pop1.head", 32'h04);
    step();
    check("pop2.count", 64'(count), 64'd2);
    out_ready = 1'b0;
    set_push(32'h10);
    step();
    set_push(32'h14);
    step();
    in_valid = 1'b0;
    check("wrap.count", 64'(count), 64'd4);
    drain_pcs = '{32'h08, 32'h0C, 32'h10, 32'h14};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("drain%0d", i), drain_pcs[i]);
      step();
    end
    check("drained.count",     64'(count),     64'd0);
    check("drained.out_valid", 64'(out_valid), 64'd0);
    // Pop on empty: nothing changes.
    step();
    check("empty_pop.count", 64'(count), 64'd0);
    out_ready = 1'b0;

    // ---- Concurrent push+pop at count=2
    set_push(32'h20);
    step();
    set_push(32'h24);
    step();
    check("conc.start_count", 64'(count), 64'd2);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_head($sformatf("conc%0d.head", i), 32'h20 + 32'(4 * i));
      set_push(32'h28 + 32'(4 * i));
      step();
      check($sformatf("conc%0d.count", i), 64'(count), 64'd2);
    end
    check_head("conc.after", 32'h34);

    // ---- Flush with a same-cycle push of 0x40 at count=3
    out_ready = 1'b0;
    set_push(32'h3C);
    step();
    check("preflush.count", 64'(count), 64'd3);
    flush     = 1'b1;
    out_ready = 1'b1;
    set_push(32'h40);
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush.count",     64'(count),     64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.in_ready",  64'(in_ready),  64'd1);
    set_push(32'h44);
    step();
    in_valid = 1'b0;
    check("postflush.count", 64'(count), 64'd1);
    check_head("postflush.head", 32'h44);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("postflush.empty", 64'(count), 64'd0);

    // ---- Reset and flush together mid-stream at count=2
    set_push(32'h50);
    step();
    set_push(32'h54);
    step();
    check("prerst.count", 64'(count), 64'd2);
    reset     = 1'b1;
    flush     = 1'b1;
    out_ready = 1'b1;
    set_push(32'h58);
    step();
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rstflush.count",     64'(count),     64'd0);
    check("rstflush.out_valid", 64'(out_valid), 64'd0);
    check("rstflush.in_ready",  64'(in_ready),  64'd1);
    set_push(32'h60);
    step();
    set_push(32'h64);
    step();
    check_head("rstflush.first", 32'h60);

    // ---- Full plus pop: push refused, count drops to 3
    set_push(32'h68);
    step();
    set_push(32'h6C);
    step();
    check("fp.count_full", 64'(count), 64'd4);
    out_ready = 1'b1;
    set_push(32'h70);
    check("fp.in_ready", 64'(in_ready), 64'd0);
    step();
    in_valid = 1'b0;
    check("fp.count", 64'(count), 64'd3);
    drain_pcs = '{32'h64, 32'h68, 32'h6C, 32'h00};
    for (int i = 0; i < 3; i++) begin
      check_head($sformatf("fp_drain%0d", i), drain_pcs[i]);
      step();
    end
    check("fp.end_count",     64'(count),     64'd0);
    check("fp.end_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_queue

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_SIZE, default `ADDR_SIZE, PC width.
REQ-002 Parameter INSTR_SIZE, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 4, entry count; power of two, at least 2.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous and active-high.
REQ-006 flush  input  1  discard all entries; driven high on jump, branch or exception redirect.
REQ-007 in_valid  input  1  fetch presents an entry.
REQ-008 in_pc  input  ADDR_SIZE  PC of the entry (fetch new_pc).
REQ-009 in_instr  input  INSTR_SIZE  instruction word at in_pc.
REQ-010 in_ready  output  1  queue accepts an entry this cycle.
REQ-011 out_valid  output  1  head entry available to decode.
REQ-012 out_pc  output  ADDR_SIZE  PC of the head entry.
REQ-013 out_instr  output  INSTR_SIZE  instruction word of the head entry.
REQ-014 out_ready  input  1  decode consumes the head this cycle.
REQ-015 count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-016 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-017 in_ready shall equal (count != DEPTH), combinationally from registered state; a full queue refuses a push even when a pop occurs in the same cycle.
REQ-018 out_valid shall equal (count != 0); out_pc and out_instr shall be read from storage at the read pointer (first-word fall-through).
REQ-019 Latency: an entry pushed at edge N shall be visible on out_* after edge N when the queue was empty; no same-cycle bypass from in_* to out_*.
REQ-020 Ordering: entries shall leave in strict push order with pc and instr kept paired.
REQ-021 Read and write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 A simultaneous push and pop on a non-full, non-empty queue shall leave count unchanged and advance both pointers.
REQ-023 A pop on an empty queue and a push on a full queue are impossible by construction; state shall not change.
REQ-024 While out_valid is high and out_ready is low, out_pc and out_instr shall hold stable.
REQ-025 flush has priority over push and pop: at the edge, count becomes 0 and both pointers become 0. A same-cycle in_valid entry is dropped.
REQ-026 After a flush, in_ready shall be 1 and out_valid shall be 0 in the next cycle.
REQ-027 Storage contents need no reset or clear; only pointers and count define validity.

Reset
REQ-028 Reset shall have priority over flush. At the reset edge: count=0 and both pointers=0.
REQ-029 Outputs in and after the reset cycle: out_valid=0, in_ready=1, count=0.
REQ-030 A reset asserted mid-stream discards all entries, with no partial pop.

Structure
REQ-031 ADDR_SIZE and the instruction-width constant live in the shared define.v; the module includes it under its own include guard.
REQ-032 A flat module with no sub-module: the storage array, pointers and count logic are inline. Implementation size is about 120-200 lines.
REQ-033 The fetch stage's new_pc and instruction feed in_pc and in_instr. The fetch redirect conditions (is_jump | is_branch | is_exception) are ORed externally to form flush.

Verification
REQ-034 Fill: reset, then push pc 0x00, 0x04, 0x08, 0x0C with out_ready=0. Required: count 1..4, then in_ready=0, with out_pc=0x00 held throughout.
REQ-035 Drain and wrap: from full, pop 2, push 0x10 and 0x14, then pop all. Required: out_pc sequence 0x08, 0x0C, 0x10, 0x14 and count ends at 0.
REQ-036 Concurrent: with count=2, push and pop for 5 cycles. Required: count stays 2 and the pc order is preserved.
REQ-037 Flush: with count=3, assert flush together with in_valid (pc 0x40). Required: the next cycle has count=0, out_valid=0 and in_ready=1, and 0x40 never appears.
REQ-038 Reset versus flush: with count=2, assert reset and flush together mid-stream. Required: count=0, and the first pushed pc after reset is the first one popped.
REQ-039 Full plus pop: with count=4, set out_ready=1 and in_valid=1. Required: the push is refused and count becomes 3.
